lcd_ctrl_p: RTL and testbench

//  Parametrised LCD window controller, successor to the fixed 8x8/4x4 controller.
//  - Loads an IMG_W x IMG_H pixel image from a byte stream.
//  - After every command, streams a WIN x WIN display window in raster order.
//  - Adds horizontal/vertical flip modes and a 4-bit command code.
//  - Sits between the host command/data bus and the LCD pixel driver.

---
 rtl/lcd_ctrl_p.sv | 175 +++++++++++++++++
 tb/tb_lcd_ctrl_p.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_p.sv
// rtl/lcd_ctrl_p.sv - parametrised LCD window controller: byte-stream image load, zoom/fit/shift/flip window streaming
module lcd_ctrl_p #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

    localparam logic [XW-1:0] OX_MAX   = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] OY_MAX   = YW'(IMG_H - WIN);
    localparam logic [XW-1:0] OX_CTR   = XW'((IMG_W - WIN) / 2);
    localparam logic [YW-1:0] OY_CTR   = YW'((IMG_H - WIN) / 2);
    localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
    localparam logic [AW-1:0] PIX_LAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, RD, UPD, OUT} state_t;

    state_t        state_q, state_d;
    logic          zoom_q, zoom_d;
    logic          flip_h_q, flip_h_d;
    logic          flip_v_q, flip_v_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [AW-1:0] ld_q, ld_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;

    logic [DW-1:0] img_q [N];
    logic [CW-1:0] rr, cc;
    logic [AW-1:0] rd_addr;
    logic          accept;

    // busy covers the trailing cycle where the last pixel is still on the bus
    assign busy         = (state_q != IDLE) || valid_q;
    assign accept       = cmd_valid && !busy;
    assign dataout      = dout_q;
    assign output_valid = valid_q;

    always_comb begin
        rr = flip_v_q ? (WIN_LAST - row_q) : row_q;
        cc = flip_h_q ? (WIN_LAST - col_q) : col_q;
        if (zoom_q) begin
            rd_addr = (AW'(oy_q) + AW'(rr)) * AW'(IMG_W) + AW'(ox_q) + AW'(cc);
        end else begin
            rd_addr = AW'(rr) * AW'((IMG_H / WIN) * IMG_W) + AW'(cc) * AW'(IMG_W / WIN);
        end
    end

    // Image RAM is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == RD) begin
            img_q[ld_q] <= datain;
        end
    end

    always_comb begin
        state_d  = state_q;
        zoom_d   = zoom_q;
        flip_h_d = flip_h_q;
        flip_v_d = flip_v_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        cmd_d    = cmd_q;
        ld_d     = ld_q;
        row_d    = row_q;
        col_d    = col_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d   = cmd;
                    ld_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = (cmd == 4'd1) ? RD : UPD;
                end
            end
            RD: begin
                ld_d = ld_q + 1'b1;
                if (ld_q == PIX_LAST) begin
                    state_d  = OUT;
                    zoom_d   = 1'b0;
                    ox_d     = OX_CTR;
                    oy_d     = OY_CTR;
                    flip_h_d = 1'b0;
                    flip_v_d = 1'b0;
                end
            end
            UPD: begin
                state_d = OUT;
                case (cmd_q)
                    4'd2: begin
                        if (!zoom_q) begin
                            zoom_d = 1'b1;
                            ox_d   = OX_CTR;
                            oy_d   = OY_CTR;
                        end
                    end
                    4'd3: zoom_d = 1'b0;
                    4'd4: if (zoom_q && ox_q < OX_MAX) ox_d = ox_q + 1'b1;
                    4'd5: if (zoom_q && ox_q != '0) ox_d = ox_q - 1'b1;
                    4'd6: if (zoom_q && oy_q != '0) oy_d = oy_q - 1'b1;
                    4'd7: if (zoom_q && oy_q < OY_MAX) oy_d = oy_q + 1'b1;
                    4'd8: flip_h_d = !flip_h_q;
                    4'd9: flip_v_d = !flip_v_q;
                    default: ;
                endcase
            end
            OUT: begin
                valid_d = 1'b1;
                dout_d  = img_q[rd_addr];
                if (col_q == WIN_LAST) begin
                    col_d = '0;
                    if (row_q == WIN_LAST) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            zoom_q   <= 1'b0;
            flip_h_q <= 1'b0;
            flip_v_q <= 1'b0;
            ox_q     <= OX_CTR;
            oy_q     <= OY_CTR;
            cmd_q    <= '0;
            ld_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            zoom_q   <= zoom_d;
            flip_h_q <= flip_h_d;
            flip_v_q <= flip_v_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            cmd_q    <= cmd_d;
            ld_q     <= ld_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end
endmodule

// File: tb/tb_lcd_ctrl_p.sv
// tb/tb_lcd_ctrl_p.sv - self-checking bench for lcd_ctrl_p against a window-level reference model
module tb_lcd_ctrl_p;
    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int WIN   = 4;
    localparam int N     = IMG_W * IMG_H;
    localparam int WW    = WIN * WIN;
    localparam int CX    = (IMG_W - WIN) / 2;
    localparam int CY    = (IMG_H - WIN) / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    lcd_ctrl_p #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
        .clk(clk),
        .reset(reset),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .datain(datain),
        .dataout(dataout),
        .output_valid(output_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    int img [N];
    bit zoom = 0;
    bit fh = 0;
    bit fv = 0;
    int ox = CX;
    int oy = CY;
    int win [WW];
    int acc = -1000;
    int lat = 0;
    int last_out = 0;
    bit chk_en = 1;

    task automatic check(input string nm, input logic [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, expv);
        end
    endtask

    function automatic void model_window();
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                int rr, cc;
                rr = fv ? WIN - 1 - r : r;
                cc = fh ? WIN - 1 - c : c;
                if (zoom) win[r*WIN+c] = img[(oy + rr) * IMG_W + ox + cc];
                else      win[r*WIN+c] = img[rr * (IMG_H / WIN) * IMG_W + cc * (IMG_W / WIN)];
            end
        end
    endfunction

    function automatic void apply(input int c);
        case (c)
            2: if (!zoom) begin zoom = 1; ox = CX; oy = CY; end
            3: zoom = 0;
            4: if (zoom && ox < IMG_W - WIN) ox++;
            5: if (zoom && ox > 0) ox--;
            6: if (zoom && oy > 0) oy--;
            7: if (zoom && oy < IMG_H - WIN) oy++;
            8: fh = !fh;
            9: fv = !fv;
            default: ;
        endcase
    endfunction

    // Per-cycle compare: busy/valid windows derived from acceptance cycle and latency
    always @(negedge clk) begin
        if (chk_en) begin
            bit eb, ev;
            eb = (cyc >= acc) && (cyc <= acc + lat + WW - 1);
            ev = (cyc >= acc + lat) && (cyc <= acc + lat + WW - 1);
            if (ev) last_out = win[cyc - acc - lat];
            check("busy", busy, int'(eb));
            check("output_valid", output_valid, int'(ev));
            check("dataout", dataout, last_out);
        end
    end

    task automatic start_cmd(input int c, input bit rnd_img, input bit noise);
        @(negedge clk);
        while (cyc <= acc + lat + WW - 1) @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cmd = 4'(c);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (c == 1) begin
            lat = N + 1;
            acc = cyc;
            for (int k = 0; k < N; k++) begin
                int v;
                v = rnd_img ? int'($urandom_range(0, 255)) : k;
                datain = DW'(v);
                img[k] = v;
                if (noise) begin
                    cmd_valid = ($urandom_range(0, 2) == 0);
                    cmd = 4'($urandom_range(0, 15));
                end
                @(posedge clk);
                #1;
            end
            zoom = 0; ox = CX; oy = CY; fh = 0; fv = 0;
        end else begin
            lat = 2;
            acc = cyc;
            apply(c);
        end
        model_window();
    endtask

    task automatic finish_cmd(input bit noise);
        while (cyc < acc + lat + WW - 1) begin
            if (noise) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                cmd = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input int c, input bit noise);
        start_cmd(c, 1'b0, noise);
        finish_cmd(noise);
    endtask

    task automatic pin_row0(input string nm, input int a, input int b, input int c, input int d);
        check({nm, "[0]"}, win[0], a);
        check({nm, "[1]"}, win[1], b);
        check({nm, "[2]"}, win[2], c);
        check({nm, "[3]"}, win[3], d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t1 [WW];
        int loads;
        t1 = '{'h00, 'h02, 'h04, 'h06, 'h10, 'h12, 'h14, 'h16,
               'h20, 'h22, 'h24, 'h26, 'h30, 'h32, 'h34, 'h36};
        repeat (3) @(negedge clk);
        reset = 1'b1;

        issue(1, 0);
        for (int i = 0; i < WW; i++) check("pin_load", win[i], t1[i]);

        issue(2, 0);
        pin_row0("pin_zoom", 'h12, 'h13, 'h14, 'h15);
        check("pin_zoom_r1", win[4], 'h1A);
        issue(4, 0); check("pin_sr1", win[0], 'h13);
        issue(4, 0); check("pin_sr2", win[0], 'h14);
        issue(4, 0); check("pin_sr3", win[0], 'h14);

        issue(3, 0);
        issue(2, 0); check("pin_rezoom", win[0], 'h12);
        issue(6, 0); pin_row0("pin_su1", 'h0A, 'h0B, 'h0C, 'h0D);
        issue(6, 0); pin_row0("pin_su2", 'h02, 'h03, 'h04, 'h05);
        issue(6, 0); pin_row0("pin_su3", 'h02, 'h03, 'h04, 'h05);

        issue(3, 0);
        issue(2, 0);
        issue(8, 0); pin_row0("pin_fh", 'h15, 'h14, 'h13, 'h12);
        issue(9, 0); pin_row0("pin_fv", 'h2D, 'h2C, 'h2B, 'h2A);
        issue(3, 0); pin_row0("pin_fit_flip", 'h36, 'h34, 'h32, 'h30);

        issue(2, 1);
        issue(5, 1);
        issue(15, 1);

        // reset in the middle of an output burst
        start_cmd(0, 1'b0, 1'b0);
        while (cyc < acc + lat + 5) begin @(posedge clk); #1; end
        @(negedge clk);
        #2;
        chk_en = 0;
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", output_valid, 0);
        check("rst_dataout", dataout, 0);
        zoom = 0; ox = CX; oy = CY; fh = 0; fv = 0;
        acc = -1000; lat = 0; last_out = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1;
        issue(0, 0);
        pin_row0("pin_post_rst", 'h00, 'h02, 'h04, 'h06);

        loads = 0;
        for (int it = 0; it < 60; it++) begin
            int c;
            c = $urandom_range(0, 15);
            if (c == 1 && loads >= 3) c = 0;
            if (c == 1) loads++;
            start_cmd(c, 1'b1, 1'($urandom_range(0, 1)));
            finish_cmd(1'($urandom_range(0, 1)));
        end
        start_cmd(1, 1'b1, 1'b1);
        finish_cmd(1'b1);
        issue(2, 0);
        issue(7, 1);

        @(negedge clk);
        while (cyc <= acc + lat + WW + 1) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
